// File: rtl/alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// alu_op_sequencer
//
// Command-side master for an external combinational ALU. One command is taken
// over a valid/ready handshake and the ALU is then driven one pass per clock
// through registered alu_sel/alu_a/alu_b. The ALU result is captured at the end
// of each pass, and the final pass is returned as a held response.
//
// The ALU has no multi-bit shift and no subtract, so these are built from
// several passes:
//   SHL/SHR by N : N iterated 1-bit shifts, each pass feeding y back into a.
//                  A count of 0 becomes a single OR pass with b=0, giving a.
//   SUB a-b      : ~b (NOT pass), a + ~b (ADD pass), then +1 (ADD pass).
//
// Ports
//   clk, rst             clock (rising edge); asynchronous active-high reset
//   cmd_valid/cmd_ready  command handshake; cmd_ready = idle and not in reset
//   cmd_op/a/b/cnt       opcode, operands, shift count (SHL/SHR only)
//   alu_sel/a/b          registered drive to the ALU
//   alu_y/alu_zero       combinational ALU result for the current pass
//   rsp_valid/rsp_ready  response handshake; rsp_* hold until consumed
//   rsp_data/rsp_zero    result and zero flag of the final ALU pass
//   rsp_carry            only with ALU_SEQ_CARRY_EN: carry-out (ADD) or last
//                        bit shifted out (SHL/SHR), 0 for every other op
//
// Configuration macro: ALU_SEQ_CARRY_EN (adds rsp_carry and its logic).
// -----------------------------------------------------------------------------
module alu_op_sequencer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [CNT_W-1:0] cmd_cnt,
  output logic [2:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero
`ifdef ALU_SEQ_CARRY_EN
  ,
  output logic             rsp_carry
`endif
);

  // Command opcodes. OR..SHR share their encoding with the ALU select field,
  // so single-pass ops and shift passes drive the opcode straight through.
  localparam logic [2:0] OP_OR  = 3'b000;
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_SUB = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PASS,
    S_SUB_NOT,
    S_SUB_ADD,
    S_SUB_INC,
    S_DONE
  } state_t;

  state_t           state_reg;
  logic [2:0]       op_reg;   // accepted opcode
  logic [WIDTH-1:0] a_reg;    // accepted a; needed again in the SUB ADD pass
  logic [CNT_W-1:0] cnt_reg;  // remaining shift passes, including the current one

  logic is_shift;
  logic shift_more;
  logic capture;

  // Accept only while idle; forced low during reset so nothing can be taken
  // on the edge that releases it.
  assign cmd_ready = (state_reg == S_IDLE) & ~rst;

  assign is_shift = (op_reg == OP_SHL) || (op_reg == OP_SHR);

  // Another shift pass is needed when more than the current pass remains.
  // A zero count runs as an OR pass and never loops, since cnt_reg is 0.
  assign shift_more = (state_reg == S_PASS) && is_shift && (cnt_reg > CNT_W'(1));

  // The current pass is the last one of the op: its y/zero become the response.
  assign capture = ((state_reg == S_PASS) && !shift_more) || (state_reg == S_SUB_INC);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= S_IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      cnt_reg   <= '0;
      alu_sel   <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_zero  <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (cmd_valid) begin
            op_reg  <= cmd_op;
            a_reg   <= cmd_a;
            cnt_reg <= cmd_cnt;
            case (cmd_op)
              OP_SHL, OP_SHR: begin
                // A zero-count shift still makes one pass, returning a unchanged.
                alu_sel   <= (cmd_cnt != '0) ? cmd_op : OP_OR;
                alu_a     <= cmd_a;
                alu_b     <= '0;
                state_reg <= S_PASS;
              end
              OP_SUB: begin
                // First SUB pass inverts b, so b rides on the ALU a input.
                alu_sel   <= OP_NOT;
                alu_a     <= cmd_b;
                alu_b     <= '0;
                state_reg <= S_SUB_NOT;
              end
              default: begin
                alu_sel   <= cmd_op;
                alu_a     <= cmd_a;
                alu_b     <= cmd_b;
                state_reg <= S_PASS;
              end
            endcase
          end
        end

        S_PASS: begin
          if (shift_more) begin
            // Feed the 1-bit shifted value back for the next pass.
            alu_a   <= alu_y;
            cnt_reg <= cnt_reg - CNT_W'(1);
          end else begin
            state_reg <= S_DONE;
          end
        end

        S_SUB_NOT: begin
          // a + ~b
          alu_sel   <= OP_ADD;
          alu_a     <= a_reg;
          alu_b     <= alu_y;
          state_reg <= S_SUB_ADD;
        end

        S_SUB_ADD: begin
          // (a + ~b) + 1 completes the two's-complement subtract.
          alu_sel   <= OP_ADD;
          alu_a     <= alu_y;
          alu_b     <= WIDTH'(1);
          state_reg <= S_SUB_INC;
        end

        S_SUB_INC: begin
          state_reg <= S_DONE;
        end

        S_DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state_reg <= S_IDLE;
          end
        end

        default: begin
          state_reg <= S_IDLE;
        end
      endcase

      // Response registers load only at the end of the final pass and then
      // hold through DONE until the consumer takes them.
      if (capture) begin
        rsp_valid <= 1'b1;
        rsp_data  <= alu_y;
        rsp_zero  <= alu_zero;
      end
    end
  end

`ifdef ALU_SEQ_CARRY_EN
  logic carry_next;

  // Carry of the final pass. Only single-pass ADD and shift passes produce
  // one; SUB finishes in SUB_INC and so always reports 0.
  always_comb begin
    carry_next = 1'b0;
    if (state_reg == S_PASS) begin
      case (op_reg)
        OP_ADD: carry_next = (alu_a[WIDTH-1] & alu_b[WIDTH-1]) |
                             ((alu_a[WIDTH-1] | alu_b[WIDTH-1]) & ~alu_y[WIDTH-1]);
        // The bit leaving the word on this 1-bit pass; none for a zero count.
        OP_SHL: carry_next = (cnt_reg != '0) & alu_a[WIDTH-1];
        OP_SHR: carry_next = (cnt_reg != '0) & alu_a[0];
        default: carry_next = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_carry <= 1'b0;
    end else if (capture) begin
      rsp_carry <= carry_next;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_op_sequencer
//
// Drives alu_op_sequencer against a behavioural combinational ALU. Expected
// results come from plain arithmetic on the command (a+b, a-b, a<<cnt, ...),
// and expected latency from the op class, not from the pass sequence.
// -----------------------------------------------------------------------------
module tb_alu_op_sequencer;

  localparam int WIDTH = 32;
  localparam int CNT_W = 5;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [2:0]       cmd_op = '0;
  logic [WIDTH-1:0] cmd_a = '0;
  logic [WIDTH-1:0] cmd_b = '0;
  logic [CNT_W-1:0] cmd_cnt = '0;
  logic [2:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_y;
  logic             alu_zero;
  logic             rsp_valid;
  logic             rsp_ready = 1'b0;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_zero;
`ifdef ALU_SEQ_CARRY_EN
  logic             rsp_carry;
`endif

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_a     (cmd_a),
    .cmd_b     (cmd_b),
    .cmd_cnt   (cmd_cnt),
    .alu_sel   (alu_sel),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_y     (alu_y),
    .alu_zero  (alu_zero),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_zero  (rsp_zero)
`ifdef ALU_SEQ_CARRY_EN
    ,
    .rsp_carry (rsp_carry)
`endif
  );

  // Behavioural combinational ALU.
  function automatic logic [WIDTH-1:0] alu_f(input logic [2:0] s,
                                             input logic [WIDTH-1:0] x,
                                             input logic [WIDTH-1:0] y);
    case (s)
      3'b000:  return x | y;
      3'b001:  return x & y;
      3'b010:  return x + y;
      3'b011:  return x ^ y;
      3'b100:  return ~x;
      3'b101:  return x << 1;
      3'b110:  return x >> 1;
      default: return '0;
    endcase
  endfunction

  assign alu_y    = alu_f(alu_sel, alu_a, alu_b);
  assign alu_zero = (alu_y == '0);

  // Reference model: what the command means, independent of how it is sequenced.
  function automatic logic [WIDTH-1:0] ref_result(input logic [2:0] op,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b,
                                                  input int cnt);
    case (op)
      3'd0: return a | b;
      3'd1: return a & b;
      3'd2: return a + b;
      3'd3: return a ^ b;
      3'd4: return ~a;
      3'd5: return (cnt >= WIDTH) ? '0 : (a << cnt);
      3'd6: return (cnt >= WIDTH) ? '0 : (a >> cnt);
      default: return a - b;
    endcase
  endfunction

  function automatic int ref_latency(input logic [2:0] op, input int cnt);
    if (op == 3'd5 || op == 3'd6) return (cnt == 0) ? 1 : cnt;
    if (op == 3'd7) return 3;
    return 1;
  endfunction

  function automatic logic ref_carry(input logic [2:0] op,
                                     input logic [WIDTH-1:0] a,
                                     input logic [WIDTH-1:0] b,
                                     input int cnt);
    logic [WIDTH:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (op == 3'd2) return s[WIDTH];
    if (op == 3'd5 && cnt > 0 && cnt <= WIDTH) return a[WIDTH-cnt];
    if (op == 3'd6 && cnt > 0 && cnt <= WIDTH) return a[cnt-1];
    return 1'b0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
  endtask

  // One full transaction: issue, measure latency, check the held response,
  // consume it and check the return to idle.
  task automatic do_op(input logic [2:0] op, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input int cnt, input int hold);
    logic [WIDTH-1:0] expd;
    int               expl;
    int               lat;
    logic             busy_ready;
    expd = ref_result(op, a, b, cnt);
    expl = ref_latency(op, cnt);

    @(negedge clk);
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    cmd_cnt   = CNT_W'(cnt);
    cmd_valid = 1'b1;
    #1 chk("cmd_ready_idle", cmd_ready, 1);
    @(posedge clk);
    #1;
    // Garbage on the idle command bus must not disturb the op in flight.
    cmd_valid = 1'b0;
    cmd_op    = 3'($urandom);
    cmd_a     = $urandom;
    cmd_b     = $urandom;
    cmd_cnt   = CNT_W'($urandom);

    lat = 0;
    busy_ready = 1'b0;
    while (lat < 200) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (rsp_valid) break;
      if (cmd_ready) busy_ready = 1'b1;
    end
    chk("latency", lat, expl);
    chk("rsp_data", rsp_data, expd);
    chk("rsp_zero", rsp_zero, expd == '0);
    chk("cmd_ready_busy", busy_ready, 0);
`ifdef ALU_SEQ_CARRY_EN
    chk("rsp_carry", rsp_carry, ref_carry(op, a, b, cnt));
`endif

    for (int i = 0; i < hold; i++) @(negedge clk);
    if (hold > 0) begin
      chk("rsp_valid_held", rsp_valid, 1);
      chk("rsp_data_held", rsp_data, expd);
      chk("rsp_zero_held", rsp_zero, expd == '0);
    end
    chk("cmd_ready_done", cmd_ready, 0);

    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    chk("rsp_valid_drop", rsp_valid, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    $display("op=%0d a=%h b=%h cnt=%0d hold=%0d -> data=%h zero=%b lat=%0d",
             op, a, b, cnt, hold, rsp_data, rsp_zero, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]       rop;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             seen_valid;

    // Reset state, with a command offered that must not be taken.
    cmd_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_zero", rsp_zero, 0);
    chk("rst_alu_sel", alu_sel, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    cmd_valid = 1'b0;
    rst = 1'b0;

    // Directed cases.
    do_op(3'd2, 32'h7, 32'h9, 0, 0);                 // ADD -> 0x10
    do_op(3'd7, 32'h5, 32'h5, 0, 0);                 // SUB -> 0, zero
    do_op(3'd7, 32'h3, 32'h5, 0, 0);                 // SUB wraps -> 0xFFFFFFFE
    do_op(3'd5, 32'h1, 32'h0, 31, 0);                // SHL 31 -> 0x80000000
    do_op(3'd6, 32'hF0, 32'h0, 0, 0);                // SHR 0 -> 0xF0
    do_op(3'd1, 32'hF0, 32'h0F, 0, 5);               // AND held 5 cycles
    do_op(3'd0, 32'h1234_0000, 32'h0000_5678, 0, 1); // OR
    do_op(3'd3, 32'hA5A5_A5A5, 32'hFFFF_0000, 0, 0); // XOR
    do_op(3'd4, 32'hFFFF_FFFF, 32'h1234, 0, 0);      // NOT -> 0, zero
    do_op(3'd6, 32'h8000_0001, 32'h0, 1, 0);         // SHR 1
`ifdef ALU_SEQ_CARRY_EN
    do_op(3'd2, 32'hFFFF_FFFF, 32'h1, 0, 0);         // ADD carry out
    do_op(3'd6, 32'h3, 32'h0, 1, 0);                 // SHR carry out
`endif

    // Reset during the 10th pass of a 20-pass shift aborts it silently.
    @(negedge clk);
    cmd_op    = 3'd5;
    cmd_a     = 32'h0000_0003;
    cmd_b     = '0;
    cmd_cnt   = CNT_W'(20);
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_cmd_ready", cmd_ready, 0);
    chk("abort_alu_sel_async", alu_sel, 0);
    @(negedge clk);
    rst = 1'b0;
    seen_valid = 1'b0;
    repeat (25) begin
      @(negedge clk);
      if (rsp_valid) seen_valid = 1'b1;
    end
    chk("abort_no_rsp", seen_valid, 0);
    chk("abort_cmd_ready_after", cmd_ready, 1);
    $display("abort: shl cnt=20 reset at pass 10, no response");
    do_op(3'd2, 32'h1, 32'h1, 0, 0);                 // ADD 1+1 -> 2

    // Randomized commands against the reference model.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? ra : $urandom;
      if ($urandom_range(0, 7) == 0) ra = '0;
      do_op(rop, ra, rb, $urandom_range(0, 31), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
